// File: rtl/quadrilatero_pkg.sv
// Shared types and the row generator for the matrix-register fill engine.
// Contents:
//   Rlen/Elen/NRegs/NRows/XIdWidth  default geometry (fill_req_t and fill_row use these widths)
//   fill_mode_e                     0 ZERO, 1 SPLAT, 2 IDENTITY, 3 reserved (behaves as ZERO)
//   sew_e                           0 e8, 1 e16, 2 e32, 3 reserved (behaves as e32)
//   fill_req_t                      one queued request {mreg, mode, sew, scalar, id}
//   fill_row(req, row)              data for one row of the destination register
// Configuration: QUADRILATERO_FILL_IDENTITY_EN enables IDENTITY; otherwise IDENTITY
// produces zero rows and no identity generator is built.
package quadrilatero_pkg;

  localparam int unsigned Rlen     = 128;
  localparam int unsigned Elen     = 32;
  localparam int unsigned NRegs    = 8;
  localparam int unsigned NRows    = 4;
  localparam int unsigned XIdWidth = 4;
  localparam int unsigned RegW     = $clog2(NRegs);
  localparam int unsigned RowW     = $clog2(NRows);

  typedef enum logic [1:0] {
    FillZero     = 2'd0,
    FillSplat    = 2'd1,
    FillIdentity = 2'd2,
    FillRsvd     = 2'd3
  } fill_mode_e;

  typedef enum logic [1:0] {
    Sew8    = 2'd0,
    Sew16   = 2'd1,
    Sew32   = 2'd2,
    SewRsvd = 2'd3
  } sew_e;

  typedef struct packed {
    logic [RegW-1:0]     mreg;
    fill_mode_e          mode;
    sew_e                sew;
    logic [Elen-1:0]     scalar;
    logic [XIdWidth-1:0] id;
  } fill_req_t;

  function automatic logic [Rlen-1:0] fill_row(fill_req_t req, logic [RowW-1:0] row);
    logic [Rlen-1:0] data;
`ifndef QUADRILATERO_FILL_IDENTITY_EN
    logic unused_row;
    unused_row = ^row;
`endif
    data = '0;
    case (req.mode)
      FillSplat: begin
        case (req.sew)
          Sew8:    for (int i = 0; i < Rlen / 8; i++)  data[i*8 +: 8]   = req.scalar[7:0];
          Sew16:   for (int i = 0; i < Rlen / 16; i++) data[i*16 +: 16] = req.scalar[15:0];
          default: for (int i = 0; i < Rlen / 32; i++) data[i*32 +: 32] = req.scalar[31:0];
        endcase
      end
`ifdef QUADRILATERO_FILL_IDENTITY_EN
      FillIdentity: begin
        // Element 'row' holds the value 1, i.e. its least significant bit is set.
        case (req.sew)
          Sew8:    data[32'(row) * 8]  = 1'b1;
          Sew16:   data[32'(row) * 16] = 1'b1;
          default: data[32'(row) * 32] = 1'b1;
        endcase
      end
`endif
      default: data = '0;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small request FIFO with optional fall-through.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         synchronous flush (empties the FIFO)
//   full_o/empty_o  status; with FALL_THROUGH an incoming push makes empty_o low at once
//   data_i/push_i   write side (ignored when full)
//   data_o/pop_i    read side (ignored when empty)
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 2,
  parameter type         dtype        = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0]  CntFull = CntW'(DEPTH);
  localparam logic [AddrW-1:0] PtrLast = AddrW'(DEPTH - 1);

  dtype             mem_q [DEPTH];
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_empty, do_push, do_pop, bypass;

  assign is_empty = (cnt_q == '0);
  assign full_o   = (cnt_q == CntFull);
  assign empty_o  = is_empty & ~(FALL_THROUGH & push_i);
  assign data_o   = (FALL_THROUGH && is_empty) ? data_i : mem_q[rd_ptr_q];
  assign do_push  = push_i & ~full_o;
  assign do_pop   = pop_i & ~empty_o;
  // Push and pop of the same word while empty: it never touches storage.
  assign bypass   = FALL_THROUGH & is_empty & do_push & do_pop;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (!bypass) begin
      if (do_push) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !bypass && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/matrix_fill_unit.sv
// Matrix-register fill engine: queues ZERO/SPLAT/IDENTITY requests and writes every row of
// the destination register through the shared RF write port, one row per granted beat.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   waddr_o/wrowaddr_o/wdata_o       destination register, row index, row data
//   we_o/wready_i/wlast_o            write request, grant, last row accepted this cycle
//   operand_reg_i/mode_i/sew_i/
//   scalar_i/instr_id_i/start_i      new request (dropped while busy_o)
//   busy_o                           request FIFO full
//   id_o                             id of the request being (or last) executed
//   finished_o/finished_ack_i/
//   finished_instr_id_o              completion handshake
// Configuration: define QUADRILATERO_FILL_IDENTITY_EN to enable IDENTITY mode.
// The geometry parameters must agree with the quadrilatero_pkg defaults.
module matrix_fill_unit
  import quadrilatero_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned RLEN       = Rlen,
  parameter int unsigned N_REGS     = NRegs,
  parameter int unsigned N_ROWS     = NRows,
  parameter int unsigned ELEN       = Elen,
  parameter int unsigned X_ID_WIDTH = XIdWidth
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic [$clog2(N_REGS)-1:0] waddr_o,
  output logic [$clog2(N_ROWS)-1:0] wrowaddr_o,
  output logic [RLEN-1:0]           wdata_o,
  output logic                      we_o,
  output logic                      wlast_o,
  input  logic                      wready_i,
  input  logic [$clog2(N_REGS)-1:0] operand_reg_i,
  input  logic [1:0]                mode_i,
  input  logic [1:0]                sew_i,
  input  logic [ELEN-1:0]           scalar_i,
  input  logic                      start_i,
  input  logic [X_ID_WIDTH-1:0]     instr_id_i,
  output logic                      busy_o,
  output logic [X_ID_WIDTH-1:0]     id_o,
  output logic                      finished_o,
  input  logic                      finished_ack_i,
  output logic [X_ID_WIDTH-1:0]     finished_instr_id_o
);

  localparam int unsigned RowCntW = $clog2(N_ROWS);
  localparam logic [RowCntW-1:0] LastRow = RowCntW'(N_ROWS - 1);

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  state_e                  state_q, state_d;
  fill_req_t               req_q, req_d, push_req, fifo_req;
  logic [RowCntW-1:0]      row_q, row_d;
  logic                    finished_q, finished_d;
  logic [X_ID_WIDTH-1:0]   finished_id_q, finished_id_d;
  logic                    fifo_full, fifo_empty, pop;
  logic                    last_row, hold_last, beat, last_beat;

  assign push_req = '{mreg:   operand_reg_i,
                      mode:   fill_mode_e'(mode_i),
                      sew:    sew_e'(sew_i),
                      scalar: scalar_i,
                      id:     instr_id_i};

  fifo_v3 #(
    .FALL_THROUGH (1'b1),
    .DEPTH        (DEPTH),
    .dtype        (fill_req_t)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (1'b1),
    .flush_i (rst_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (push_req),
    .push_i  (start_i & ~fifo_full & ~rst_i),
    .data_o  (fifo_req),
    .pop_i   (pop)
  );

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    row_d         = row_q;
    finished_d    = finished_q;
    finished_id_d = finished_id_q;

    last_row  = (row_q == LastRow);
    // The final row waits until the previous completion has been acknowledged.
    hold_last = last_row & finished_q & ~finished_ack_i;
    we_o      = (state_q == StWrite) & ~hold_last;
    beat      = we_o & wready_i;
    last_beat = beat & last_row;
    pop       = ~fifo_empty & ((state_q == StIdle) | last_beat);

    if (beat) row_d = last_row ? '0 : row_q + 1'b1;

    if (pop) begin
      req_d   = fifo_req;
      state_d = StWrite;
    end else if (last_beat) begin
      state_d = StIdle;
    end

    if (last_beat) begin
      finished_d    = 1'b1;
      finished_id_d = req_q.id;
    end else if (finished_ack_i) begin
      finished_d    = 1'b0;
      finished_id_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      req_q         <= '0;
      row_q         <= '0;
      finished_q    <= 1'b0;
      finished_id_q <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      row_q         <= row_d;
      finished_q    <= finished_d;
      finished_id_q <= finished_id_d;
    end
  end

  assign waddr_o             = req_q.mreg;
  assign wrowaddr_o          = row_q;
  assign wdata_o             = (state_q == StWrite) ? fill_row(req_q, row_q) : '0;
  assign wlast_o             = last_beat;
  assign busy_o              = fifo_full;
  assign id_o                = req_q.id;
  assign finished_o          = finished_q;
  assign finished_instr_id_o = finished_id_q;

endmodule

// File: tb/tb_matrix_fill_unit.sv
module tb_matrix_fill_unit;

  localparam int DEPTH  = 2;
  localparam int RLEN   = 128;
  localparam int N_ROWS = 4;

  typedef struct packed {
    logic [2:0]  mreg;
    logic [1:0]  mode;
    logic [1:0]  sew;
    logic [31:0] scalar;
    logic [3:0]  id;
  } req_t;

  typedef struct packed {
    logic [2:0]   waddr;
    logic [1:0]   row;
    logic [127:0] data;
    logic         last;
  } beat_t;

  typedef struct packed {
    logic       busy;
    logic       we;
    logic       last;
    logic       fin;
    logic [3:0] fin_id;
    logic [3:0] id;
  } stat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   waddr, operand_reg;
  logic [1:0]   wrowaddr, mode, sew;
  logic [127:0] wdata;
  logic         we, wlast, wready, start, busy, finished, ack;
  logic [31:0]  scalar;
  logic [3:0]   instr_id, id, fin_id_out;

  always #5 clk = ~clk;

  matrix_fill_unit dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .waddr_o             (waddr),
    .wrowaddr_o          (wrowaddr),
    .wdata_o             (wdata),
    .we_o                (we),
    .wlast_o             (wlast),
    .wready_i            (wready),
    .operand_reg_i       (operand_reg),
    .mode_i              (mode),
    .sew_i               (sew),
    .scalar_i            (scalar),
    .start_i             (start),
    .instr_id_i          (instr_id),
    .busy_o              (busy),
    .id_o                (id),
    .finished_o          (finished),
    .finished_ack_i      (ack),
    .finished_instr_id_o (fin_id_out)
  );

  beat_t beat_q[$];
  stat_t stat_q[$];
  int    total = 0;
  int    bad   = 0;

  // Reference model: pending requests, the one in progress, and the completion flag.
  req_t       m_fifo[$];
  req_t       m_cur;
  bit         m_cur_v;
  int         m_row;
  bit         m_fin;
  logic [3:0] m_fin_id;
  logic [3:0] m_last_id;

  function automatic void model_reset();
    m_fifo.delete();
    m_cur     = '0;
    m_cur_v   = 1'b0;
    m_row     = 0;
    m_fin     = 1'b0;
    m_fin_id  = '0;
    m_last_id = '0;
  endfunction

  function automatic logic [127:0] ref_row(req_t r, int rw);
    int           m, w;
    logic [31:0]  v;
    logic [127:0] d;
    m = (r.mode == 2'd3) ? 0 : int'(r.mode);
`ifndef QUADRILATERO_FILL_IDENTITY_EN
    if (m == 2) m = 0;
`endif
    w = (r.sew == 2'd0) ? 8 : (r.sew == 2'd1) ? 16 : 32;
    d = '0;
    for (int e = 0; e < RLEN / w; e++) begin
      if (m == 1)      v = (w == 32) ? r.scalar : (r.scalar & ((32'd1 << w) - 32'd1));
      else if (m == 2) v = (e == rw) ? 32'd1 : 32'd0;
      else             v = 32'd0;
      d = d | (128'(v) << (e * w));
    end
    return d;
  endfunction

  function automatic req_t mk(int r, int md, int sw, logic [31:0] sc, int i);
    req_t q;
    q.mreg   = 3'(r);
    q.mode   = 2'(md);
    q.sew    = 2'(sw);
    q.scalar = sc;
    q.id     = 4'(i);
    return q;
  endfunction

  task automatic cycle(input bit st, input req_t r, input bit wr, input bit ak, input bit rs);
    bit m_busy, last_row, hold, m_we, acc, lst;
    @(negedge clk);
    rst         = rs;
    start       = st;
    operand_reg = r.mreg;
    mode        = r.mode;
    sew         = r.sew;
    scalar      = r.scalar;
    instr_id    = r.id;
    wready      = wr;
    ack         = ak;

    m_busy   = (m_fifo.size() == DEPTH);
    last_row = (m_row == N_ROWS - 1);
    hold     = m_cur_v && last_row && m_fin && !ak;
    m_we     = m_cur_v && !hold;
    acc      = m_we && wr;
    lst      = acc && last_row;
    stat_q.push_back('{m_busy, m_we, lst, m_fin, m_fin_id, m_last_id});
    if (acc) beat_q.push_back('{m_cur.mreg, 2'(m_row), ref_row(m_cur, m_row), lst});

    if (rs) begin
      model_reset();
    end else begin
      if (st && !m_busy) m_fifo.push_back(r);
      if (acc) m_row = lst ? 0 : m_row + 1;
      if (lst) begin
        m_fin    = 1'b1;
        m_fin_id = m_cur.id;
      end else if (ak) begin
        m_fin    = 1'b0;
        m_fin_id = '0;
      end
      if ((!m_cur_v || lst) && m_fifo.size() > 0) begin
        m_cur     = m_fifo.pop_front();
        m_cur_v   = 1'b1;
        m_row     = 0;
        m_last_id = m_cur.id;
      end else if (lst) begin
        m_cur_v = 1'b0;
      end
    end
  endtask

  task automatic idle(input bit wr, input bit ak);
    cycle(1'b0, '0, wr, ak, 1'b0);
  endtask

  // Monitor: compares status every cycle and each granted row against the scoreboard.
  initial begin
    stat_t s, gs;
    beat_t b, gb;
    forever begin
      @(negedge clk);
      #2;
      if (stat_q.size() > 0) begin
        s  = stat_q.pop_front();
        gs = '{busy, we, wlast, finished, fin_id_out, id};
        total++;
        if (gs !== s) begin
          bad++;
          $display("FAIL status t=%0t got busy/we/last/fin/finid/id=%h want=%h", $time, gs, s);
        end
      end
      if (we === 1'b1 && wready === 1'b1) begin
        total++;
        if (beat_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat t=%0t got row=%0d want=no beat", $time, wrowaddr);
        end else begin
          b  = beat_q.pop_front();
          gb = '{waddr, wrowaddr, wdata, wlast};
          if (gb !== b) begin
            bad++;
            $display("FAIL beat t=%0t got=%h want=%h", $time, gb, b);
          end
        end
      end
    end
  end

  initial begin
    req_t r;
    rst = 1'b1; start = 1'b0; operand_reg = '0; mode = '0; sew = '0;
    scalar = '0; instr_id = '0; wready = 1'b0; ack = 1'b0;
    model_reset();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0);

    // ZERO, reg 3, id 5, always granted.
    cycle(1'b1, mk(3, 0, 0, 32'hFFFF_FFFF, 5), 1'b1, 1'b0, 1'b0);
    repeat (6) idle(1'b1, 1'b0);
    // SPLAT e8/e16/e32, IDENTITY e32/e8, reserved mode and sew.
    cycle(1'b1, mk(1, 1, 0, 32'h1234_56A5, 1), 1'b1, 1'b1, 1'b0);
    repeat (6) idle(1'b1, 1'b1);
    cycle(1'b1, mk(2, 1, 1, 32'hABCD_1234, 2), 1'b1, 1'b1, 1'b0);
    repeat (6) idle(1'b1, 1'b1);
    cycle(1'b1, mk(4, 1, 2, 32'hDEAD_BEEF, 3), 1'b1, 1'b1, 1'b0);
    repeat (6) idle(1'b1, 1'b1);
    cycle(1'b1, mk(0, 2, 2, 32'h0, 4), 1'b1, 1'b1, 1'b0);
    repeat (6) idle(1'b1, 1'b1);
    cycle(1'b1, mk(7, 2, 0, 32'h0, 6), 1'b1, 1'b1, 1'b0);
    repeat (6) idle(1'b1, 1'b1);
    cycle(1'b1, mk(5, 3, 3, 32'h5555_AAAA, 7), 1'b1, 1'b1, 1'b0);
    cycle(1'b1, mk(6, 1, 3, 32'h8765_4321, 8), 1'b1, 1'b1, 1'b0);
    repeat (10) idle(1'b1, 1'b1);

    // Grant toggling 1010: four rows take eight cycles.
    cycle(1'b1, mk(5, 1, 1, 32'h0000_C0DE, 9), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) idle((i % 2) == 0, 1'b1);
    repeat (3) idle(1'b1, 1'b1);

    // Back-to-back requests with completion ack withheld; fourth start hits a full FIFO.
    cycle(1'b1, mk(1, 1, 0, 32'h11, 10), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, mk(2, 1, 0, 32'h22, 11), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, mk(3, 1, 0, 32'h33, 12), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, mk(4, 1, 0, 32'h44, 13), 1'b1, 1'b0, 1'b0);
    repeat (10) idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    repeat (6) idle(1'b1, 1'b0);
    repeat (8) idle(1'b1, 1'b1);

    // Reset while row 2 is being written.
    cycle(1'b1, mk(6, 1, 2, 32'hCAFE_F00D, 14), 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    repeat (4) idle(1'b1, 1'b0);

    // Randomized traffic.
    repeat (3000) begin
      r = mk($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3), $urandom(),
             $urandom_range(0, 15));
      cycle($urandom_range(0, 2) == 0, r, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 299) == 0);
    end
    repeat (20) idle(1'b1, 1'b1);

    @(negedge clk);
    #3;
    total++;
    if (beat_q.size() != 0 || stat_q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending beats=%0d status=%0d want=0", beat_q.size(), stat_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
